// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline interlock / flush controller: register and HiLo hazards,
//            MEM-stage redirects and a multi-cycle multiplier hold FSM.
//            Optional macro HAZ_FWD_EN: datapath forwards, load-use only.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       use_rs_id,
  input  logic       use_rt_id,
  input  logic       mf_id,
  input  logic [4:0] wn_ex,
  input  logic [4:0] wn_mem,
  input  logic [4:0] wn_wb,
  input  logic       regwrite_ex,
  input  logic       regwrite_mem,
  input  logic       regwrite_wb,
  input  logic       memread_ex,
  input  logic       hilowrite_ex,
  input  logic       hilowrite_mem,
  input  logic       hilowrite_wb,
  input  logic       pcsrc_mem,
  input  logic       jump_mem,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       mul_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam bit         c_multi    = (MUL_LAT > 1);
  localparam logic [3:0] c_cnt_init = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic w_dep_ex, w_dep_mem, w_dep_wb;
  logic w_data_stall, w_hilo_stall, w_redirect;

  assign w_dep_ex  = regwrite_ex & (wn_ex != 5'd0) &
                     ((use_rs_id & (wn_ex == rs_id)) | (use_rt_id & (wn_ex == rt_id)));
  assign w_dep_mem = regwrite_mem & (wn_mem != 5'd0) &
                     ((use_rs_id & (wn_mem == rs_id)) | (use_rt_id & (wn_mem == rt_id)));
  assign w_dep_wb  = regwrite_wb & (wn_wb != 5'd0) &
                     ((use_rs_id & (wn_wb == rs_id)) | (use_rt_id & (wn_wb == rt_id)));

  assign mul_busy   = (r_state == BUSY);
  assign w_redirect = pcsrc_mem | jump_mem;

`ifdef HAZ_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = w_dep_mem ^ w_dep_wb ^ hilowrite_mem ^ hilowrite_wb;
  assign w_data_stall = memread_ex & w_dep_ex;
  assign w_hilo_stall = mf_id & (hilowrite_ex | mul_busy);
`else
  // Register file is not write-through, so even a WB-stage match must wait.
  logic w_unused_ld;
  assign w_unused_ld  = memread_ex;
  assign w_data_stall = w_dep_ex | w_dep_mem | w_dep_wb;
  assign w_hilo_stall = mf_id & (hilowrite_ex | hilowrite_mem | hilowrite_wb | mul_busy);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A redirect squashes the (younger) multiply, both on entry and mid-hold.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (c_multi && hilowrite_ex && !w_redirect) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = c_cnt_init;
        end
      end
      BUSY: begin
        if (w_redirect || (r_cnt == 4'd0)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (w_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mul_busy) begin
      // ID/EX is held rather than bubbled; the bubble goes in behind the multiply.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (w_data_stall | w_hilo_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (default build, MUL_LAT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_id, rt_id, wn_ex, wn_mem, wn_wb;
  logic       use_rs_id, use_rt_id, mf_id;
  logic       regwrite_ex, regwrite_mem, regwrite_wb, memread_ex;
  logic       hilowrite_ex, hilowrite_mem, hilowrite_wb, pcsrc_mem, jump_mem;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, mul_busy;

  int checks   = 0;
  int failures = 0;

  // Expected output order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, mul_busy}
  localparam logic [5:0] RUN   = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] HOLD  = 6'b000011;
  localparam logic [5:0] REDIR = 6'b111110;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       urs, urt, mf;
    logic [4:0] wex, wmem, wwb;
    logic       rwex, rwmem, rwwb, mr, hex, hmem, hwb, pcs, jmp;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  string      name_q[$];

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .mf_id(mf_id),
    .wn_ex(wn_ex), .wn_mem(wn_mem), .wn_wb(wn_wb),
    .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .memread_ex(memread_ex), .hilowrite_ex(hilowrite_ex),
    .hilowrite_mem(hilowrite_mem), .hilowrite_wb(hilowrite_wb),
    .pcsrc_mem(pcsrc_mem), .jump_mem(jump_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic mf, logic [4:0] wex, logic [4:0] wmem, logic [4:0] wwb,
                              logic rwex, logic rwmem, logic rwwb, logic mr, logic hex,
                              logic hmem, logic hwb, logic pcs, logic jmp, logic [5:0] exp);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mf = mf;
    v.wex = wex; v.wmem = wmem; v.wwb = wwb; v.rwex = rwex; v.rwmem = rwmem; v.rwwb = rwwb;
    v.mr = mr; v.hex = hex; v.hmem = hmem; v.hwb = hwb; v.pcs = pcs; v.jmp = jmp; v.exp = exp;
    return v;
  endfunction

  task automatic clr();
    rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0; mf_id = 0;
    wn_ex = 0; wn_mem = 0; wn_wb = 0; regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
    memread_ex = 0; hilowrite_ex = 0; hilowrite_mem = 0; hilowrite_wb = 0;
    pcsrc_mem = 0; jump_mem = 0;
  endtask

  task automatic drive(input vec_t v);
    rs_id = v.rs; rt_id = v.rt; use_rs_id = v.urs; use_rt_id = v.urt; mf_id = v.mf;
    wn_ex = v.wex; wn_mem = v.wmem; wn_wb = v.wwb;
    regwrite_ex = v.rwex; regwrite_mem = v.rwmem; regwrite_wb = v.rwwb;
    memread_ex = v.mr; hilowrite_ex = v.hex; hilowrite_mem = v.hmem; hilowrite_wb = v.hwb;
    pcsrc_mem = v.pcs; jump_mem = v.jmp;
  endtask

  task automatic compare_head();
    logic [5:0] act, exp;
    string      n;
    act = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, mul_busy};
    exp = exp_q.pop_front();
    n   = name_q.pop_front();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b (pc_en,ifid_en,ifid_fl,idex_fl,exmem_fl,busy)",
               n, act, exp);
    end
  endtask

  // Inputs already driven just after a rising edge; sample mid-cycle, then advance.
  task automatic step(input string n, input logic [5:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(n);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string n, input logic [5:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(n);
    #1;
    compare_head();
  endtask

  initial begin
    //                 name               rs rt urs urt mf wex wmem wwb rwex rwmem rwwb mr hex hmem hwb pcs jmp exp
    vecs.push_back(mk("idle",             0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, RUN));
    vecs.push_back(mk("lw_use_rs",        2, 0, 1, 0, 0,  2, 0, 0,  1, 0, 0,  1,  0, 0, 0,  0, 0, STALL));
    vecs.push_back(mk("reg0_no_hazard",   0, 0, 1, 0, 0,  0, 0, 0,  1, 0, 0,  1,  0, 0, 0,  0, 0, RUN));
    vecs.push_back(mk("wb_rt_match",      0, 5, 0, 1, 0,  0, 0, 5,  0, 0, 1,  0,  0, 0, 0,  0, 0, STALL));
    vecs.push_back(mk("mem_rt_match",     0, 5, 0, 1, 0,  0, 5, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, STALL));
    vecs.push_back(mk("ex_alu_rt_match",  0, 7, 0, 1, 0,  7, 0, 0,  1, 0, 0,  0,  0, 0, 0,  0, 0, STALL));
    vecs.push_back(mk("rs_not_used",      2, 0, 0, 0, 0,  2, 0, 0,  1, 0, 0,  1,  0, 0, 0,  0, 0, RUN));
    vecs.push_back(mk("no_regwrite",      2, 0, 1, 0, 0,  2, 0, 0,  0, 0, 0,  1,  0, 0, 0,  0, 0, RUN));
    vecs.push_back(mk("rt_mismatch",      0, 6, 0, 1, 0,  0, 5, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, RUN));
    vecs.push_back(mk("mf_hilo_mem",      0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0,  0,  0, 1, 0,  0, 0, STALL));
    vecs.push_back(mk("mf_hilo_wb",       0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0,  0,  0, 0, 1,  0, 0, STALL));
    vecs.push_back(mk("hilo_without_mf",  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0,  0, 0, 1,  0, 0, RUN));
    vecs.push_back(mk("load_and_hilo",    2, 0, 1, 0, 1,  2, 0, 0,  1, 0, 0,  1,  0, 1, 0,  0, 0, STALL));
    vecs.push_back(mk("jump_over_stall",  2, 0, 1, 0, 0,  2, 0, 0,  1, 0, 0,  1,  0, 0, 0,  0, 1, REDIR));
    vecs.push_back(mk("branch_taken",     0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  1, 0, REDIR));

    clr();
    rst = 1'b1;
    #1;
    check_now("reset_outputs", RUN);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step(vecs[i].name, vecs[i].exp);
    end
    clr();

    // Multiply: 1 run cycle in IDLE, 3 BUSY cycles, back to IDLE; then mflo waits on HiLo WB.
    hilowrite_ex = 1'b1;
    step("mul_issue", RUN);
    hilowrite_ex = 1'b0;
    step("mul_busy_1", HOLD);
    step("mul_busy_2", HOLD);
    mf_id = 1'b1;
    step("mul_busy_3_over_mf", HOLD);
    hilowrite_wb = 1'b1;
    step("mflo_wait_wb", STALL);
    hilowrite_wb = 1'b0;
    step("mflo_go", RUN);
    clr();

    // Taken branch on the 2nd BUSY cycle squashes the multiply.
    hilowrite_ex = 1'b1;
    step("mul2_issue", RUN);
    hilowrite_ex = 1'b0;
    step("mul2_busy_1", HOLD);
    pcsrc_mem = 1'b1;
    step("redirect_in_busy", 6'b111111);
    pcsrc_mem = 1'b0;
    step("after_redirect_idle", RUN);

    // Redirect in the issue cycle blocks entry into BUSY.
    hilowrite_ex = 1'b1;
    jump_mem     = 1'b1;
    step("mul_with_jump", REDIR);
    hilowrite_ex = 1'b0;
    jump_mem     = 1'b0;
    step("no_busy_after_jump", RUN);

    // Asynchronous reset in the middle of BUSY.
    hilowrite_ex = 1'b1;
    step("mul3_issue", RUN);
    hilowrite_ex = 1'b0;
    step("mul3_busy_1", HOLD);
    #2;
    rst = 1'b1;
    check_now("async_rst_mid_busy", RUN);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("idle_after_rst", RUN);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 pending", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
